// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo
//   Integrate-and-dump decimator for the 4-tap FIR output stream, followed by
//   round/shift/saturate to signed 8 bits and a 4-entry first-word-fall-through
//   FIFO with a valid/ready sink interface.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   y_in       signed 16-bit FIR sample
//   in_valid   y_in valid this cycle
//   out_data   signed 8-bit FIFO head (0 while empty)
//   out_valid  FIFO non-empty
//   out_ready  sink accepts the head this cycle
//   level      FIFO fill count 0..4
//   sat_flag   pulse during the cycle whose FIFO write carries a clipped value
//   overflow   sticky: a result was dropped on a full FIFO; cleared by rst
module fir_decim_fifo #(
   parameter int DECIM      = 4,
   parameter int LOG2_DECIM = 2,
   parameter int SHIFT      = 4,
   parameter int DEPTH      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic signed [15:0] y_in,
   input  logic              in_valid,
   output logic signed [7:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        level,
   output logic              sat_flag,
   output logic              overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic signed [20:0] RND = 21'sd1 <<< (SHIFT - 1);

   // Round half up with 21-bit headroom so the rounding constant cannot overflow.
   function automatic logic signed [20:0] round_shift(input logic signed [19:0] d);
      logic signed [20:0] ext;
      ext = {d[19], d};
      ext = ext + RND;
      return ext >>> SHIFT;
   endfunction

   function automatic logic is_clip(input logic signed [20:0] r);
      return (r > 21'sd127) || (r < -21'sd128);
   endfunction

   function automatic logic signed [7:0] sat8(input logic signed [20:0] r);
      if (r > 21'sd127)
         return 8'sd127;
      else if (r < -21'sd128)
         return -8'sd128;
      else
         return r[7:0];
   endfunction

   // ---- stage p0: block accumulation ----
   logic signed [19:0]    acc_p0;
   logic [LOG2_DECIM-1:0] phase_p0;
   logic signed [19:0]    sum_p0;
   logic                  last_p0;

   assign sum_p0  = acc_p0 + {{4{y_in[15]}}, y_in};
   assign last_p0 = (phase_p0 == LOG2_DECIM'(DECIM - 1));

   // ---- stage p1: dump register, scaling and saturation ----
   logic signed [19:0] dump_p1;
   logic               vld_p1;
   logic signed [20:0] rnd_p1;
   logic signed [7:0]  res_p1;
   logic               clip_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0   <= '0;
         phase_p0 <= '0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         if (in_valid) begin
            if (last_p0) begin
               acc_p0   <= '0;
               phase_p0 <= '0;
               vld_p1   <= 1'b1;
            end else begin
               acc_p0   <= sum_p0;
               phase_p0 <= phase_p0 + LOG2_DECIM'(1);
            end
         end
      end
   end

   // Data-only register; vld_p1 qualifies it, so no reset needed.
   always_ff @(posedge clk) begin
      if (in_valid && last_p0)
         dump_p1 <= sum_p0;
   end

   assign rnd_p1  = round_shift(dump_p1);
   assign res_p1  = sat8(rnd_p1);
   assign clip_p1 = is_clip(rnd_p1);

   // ---- stage p2: FWFT FIFO ----
   logic signed [7:0] mem_p2 [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_p2;
   logic [PTR_W-1:0]  wr_ptr_p2;
   logic [2:0]        count_p2;
   logic              full_p2;
   logic              rd_en;
   logic              wr_en;
   logic              drop;

   assign full_p2 = (count_p2 == 3'(DEPTH));
   assign rd_en   = (count_p2 != 3'd0) && out_ready;
   // A read on the same edge frees a slot, so a full FIFO still accepts the write.
   assign wr_en   = vld_p1 && (!full_p2 || rd_en);
   assign drop    = vld_p1 && full_p2 && !rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_p2 <= '0;
         wr_ptr_p2 <= '0;
         count_p2  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_p2 <= wr_ptr_p2 + PTR_W'(1);
         if (rd_en)
            rd_ptr_p2 <= rd_ptr_p2 + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count_p2 <= count_p2 + 3'd1;
            2'b01:   count_p2 <= count_p2 - 3'd1;
            default: count_p2 <= count_p2;
         endcase
         if (drop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_p2[wr_ptr_p2] <= res_p1;
   end

   assign out_valid = (count_p2 != 3'd0);
   assign out_data  = out_valid ? mem_p2[rd_ptr_p2] : 8'sd0;
   assign level     = count_p2;
   // Reflects the value presented for writing, including one that gets dropped.
   assign sat_flag  = vld_p1 && clip_p1;

endmodule

// File: tb/tb_fir_decim_fifo.sv
module tb_fir_decim_fifo;

   localparam int DECIM = 4;
   localparam int SHIFT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic signed [15:0] y_in = '0;
   logic              in_valid = 1'b0;
   logic signed [7:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [2:0]        level;
   logic              sat_flag;
   logic              overflow;

   int n_chk = 0;
   int n_bad = 0;

   fir_decim_fifo #(.DECIM(4), .LOG2_DECIM(2), .SHIFT(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .y_in(y_in), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .sat_flag(sat_flag), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---- reference model, evaluated at negedge for the coming posedge ----
   int  exp_q[$];
   int  m_acc = 0;
   int  m_ph = 0;
   bit  pend_v = 0;
   int  pend_val = 0;
   bit  pend_sat = 0;
   bit  exp_ovf = 0;
   bit  chk_en = 0;

   always @(negedge clk) begin
      int r;
      bit rd;
      if (chk_en) begin
         chk("valid", int'(out_valid), int'(exp_q.size() > 0));
         chk("level", int'(level), exp_q.size());
         chk("data", int'(out_data), (exp_q.size() > 0) ? exp_q[0] : 0);
         chk("sat", int'(sat_flag), int'(pend_v && pend_sat));
         chk("ovf", int'(overflow), int'(exp_ovf));
      end
      if (rst) begin
         exp_q.delete();
         m_acc = 0; m_ph = 0; pend_v = 0; pend_sat = 0; exp_ovf = 0;
      end else begin
         rd = (exp_q.size() > 0) && out_ready;
         if (rd) void'(exp_q.pop_front());
         if (pend_v) begin
            if (exp_q.size() < 4) exp_q.push_back(pend_val);
            else exp_ovf = 1;
         end
         pend_v = 0; pend_sat = 0;
         if (in_valid) begin
            m_acc += int'(y_in);
            if (m_ph == DECIM - 1) begin
               r = (m_acc + (1 << (SHIFT - 1))) >>> SHIFT;
               pend_sat = (r > 127) || (r < -128);
               pend_val = (r > 127) ? 127 : (r < -128) ? -128 : r;
               pend_v = 1;
               m_acc = 0; m_ph = 0;
            end else begin
               m_ph++;
            end
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic feed(input int v, input int n);
      for (int i = 0; i < n; i++) begin
         y_in = 16'(v); in_valid = 1'b1;
         cyc();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 20;
      out_ready = 1'b1;
      while (out_valid && budget > 0) begin
         cyc();
         budget--;
      end
      out_ready = 1'b0;
      chk("drain_done", int'(out_valid), 0);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      cyc(2);
      rst = 1'b0;
      chk_en = 1;
      chk("rst_level", int'(level), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_ovf", int'(overflow), 0);

      // 1. basic
      feed(16, 4);
      chk("t1_notyet", int'(out_valid), 0);
      cyc();
      chk("t1_data", int'(out_data), 4);
      chk("t1_level", int'(level), 1);
      drain();
      chk("t1_empty_data", int'(out_data), 0);

      // 2. rounding
      feed(-2, 4); cyc(); chk("t2_m2", int'(out_data), 0); drain();
      feed(-3, 4); cyc(); chk("t2_m3", int'(out_data), -1); drain();
      feed(2, 4);  cyc(); chk("t2_p2", int'(out_data), 1); drain();

      // 3. saturation (sat_flag is visible the cycle after the 4th sample edge)
      feed(1000, 4);
      chk("t3_sat_hi", int'(sat_flag), 1);
      cyc(); chk("t3_hi", int'(out_data), 127); drain();
      feed(-1000, 4);
      chk("t3_sat_lo", int'(sat_flag), 1);
      cyc(); chk("t3_lo", int'(out_data), -128); drain();
      feed(500, 4);
      chk("t3_nosat", int'(sat_flag), 0);
      cyc(); chk("t3_mid", int'(out_data), 125); drain();

      // 4. overflow with stalled sink
      for (int v = 1; v <= 5; v++) feed(4 * v, 4);
      cyc(2);
      chk("t4_level", int'(level), 4);
      chk("t4_ovf", int'(overflow), 1);
      chk("t4_head", int'(out_data), 1);
      drain();
      chk("t4_ovf_sticky", int'(overflow), 1);
      do_rst();
      chk("t4_ovf_clr", int'(overflow), 0);

      // 5. full FIFO with read and write on the same edge
      for (int v = 1; v <= 4; v++) feed(4 * v, 4);
      cyc(2);
      chk("t5_full", int'(level), 4);
      feed(20, 4);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("t5_level", int'(level), 4);
      chk("t5_ovf", int'(overflow), 0);
      chk("t5_head", int'(out_data), 2);
      drain();

      // 6. gaps, then reset mid-block
      for (int i = 0; i < 4; i++) begin
         y_in = 16'sd16; in_valid = 1'b1; cyc();
         in_valid = 1'b0; cyc();
      end
      chk("t6_gap", int'(out_data), 4);
      drain();
      feed(99, 2);
      do_rst();
      feed(32, 4);
      cyc();
      chk("t6_after_rst", int'(out_data), 8);
      chk("t6_level", int'(level), 1);
      drain();
      cyc(3);
      chk("t6_single", int'(level), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
